generic_bus_slave: RTL and testbench
====================================

GENERIC_BUS_SLAVE -- requirements
Module: generic_bus_slave

Interface
REQ-001 SHALL have parameter IS_IO, default 0, meaning 0 = memory slave, 1 = I/O slave.
REQ-002 SHALL have parameter BASE_ADDR, default 20'h1C000, meaning window base, aligned to 2**ADDR_BITS.
REQ-003 SHALL have parameter ADDR_BITS, default 9, meaning depth of 2**ADDR_BITS bytes, range 1..16.
REQ-004 SHALL have parameter WAIT_STATES, default 2, meaning READY-low cycles per access, range 0..7.
REQ-005 SHALL have port CLK, input, 1 bit: the single clock, rising-edge.
REQ-006 SHALL have port RESET_N, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port ALE, input, 1 bit: address latch enable.
REQ-008 SHALL have port IOM, input, 1 bit: 1 = I/O cycle, 0 = memory cycle.
REQ-009 SHALL have ports RD_N and WR_N, input, 1 bit each: active-low read and write strobes.
REQ-010 SHALL have port A, input, bits [19:8]: upper address.
REQ-011 SHALL have port AD, inout, bits [7:0]: multiplexed address and data.
REQ-012 SHALL have port READY, output, 1 bit: high = access may complete.
REQ-013 SHALL have port SEL, output, 1 bit: latched address hits this slave.

Function
REQ-014 SHALL latch {A,AD} into a 20-bit address register at each CLK edge with ALE=1; ALE=1 SHALL restart the FSM from any state.
REQ-015 SHALL compute the hit from IOM==IS_IO and address inside [BASE_ADDR, BASE_ADDR+2**ADDR_BITS-1]; when IS_IO=1 only bits [15:0] SHALL be compared.
REQ-016 SHALL index storage with offset = address[ADDR_BITS-1:0]; SEL SHALL be registered with the address.
REQ-017 SHALL implement FSM states IDLE, LATCHED, WAIT, ACCESS, DONE.
REQ-018 SHALL go IDLE->LATCHED on ALE; LATCHED->IDLE if no hit; LATCHED->WAIT (load counter WAIT_STATES) on first edge with hit and exactly one strobe low, or ->ACCESS if WAIT_STATES=0.
REQ-019 SHALL decrement in WAIT and go WAIT->ACCESS when the counter reaches 1; READY SHALL be registered low exactly while in WAIT.
REQ-020 SHALL, on entry to ACCESS, write AD to storage for a write or load the read register for a read.
REQ-021 SHALL go ACCESS->DONE unconditionally, and DONE->IDLE when RD_N=WR_N=1.
REQ-022 SHALL drive AD with the read register only in ACCESS or DONE of a read cycle while RD_N=0; otherwise AD SHALL be high-Z.
REQ-023 SHALL treat RD_N=WR_N=0 as illegal: no state advance from LATCHED, no write, no drive.
REQ-024 SHALL, on a miss, never drive AD, never write, and hold READY=1.
REQ-025 SHALL, for a hit with strobe first sampled low at edge e, make data or write effective at edge e+WAIT_STATES.

Reset
REQ-026 SHALL, while RESET_N=0, force IDLE, READY=1, SEL=0, AD high-Z, and clear the address register and counter immediately.
REQ-027 SHALL NOT clear storage contents on reset; reset mid-access SHALL abort without a write.

Configuration
REQ-028 SHALL use macro GBS_WAITSTATE_EN: defined = WAIT state and counter built, READY as specified; undefined = WAIT omitted, READY tied 1, WAIT_STATES ignored, LATCHED goes straight to ACCESS.

Verification
REQ-029 SHALL cover: defaults, write 8'hA5 to 20'h1C005, then read -> AD=8'hA5, READY low exactly 2 cycles per access.
REQ-030 SHALL cover: read and write at 20'h1C200 (outside window) -> AD stays Z, READY=1, SEL=0, storage unchanged.
REQ-031 SHALL cover: IS_IO=1, BASE_ADDR=16'hFF00, ADDR_BITS=4: IOM=0 cycle at FF03 is ignored; IOM=1 write 8'h3C at 0xFF03 with A[19:16]=4'hF, then read -> 8'h3C.
REQ-032 SHALL cover: RESET_N pulsed low during WAIT -> READY=1 and AD=Z asynchronously, no write; earlier data at 1C005 reads back 8'hA5.
REQ-033 SHALL cover: RD_N=WR_N=0 on a hit -> FSM holds LATCHED, AD Z, no write; ALE mid-DONE restarts to LATCHED.
REQ-034 SHALL cover: GBS_WAITSTATE_EN undefined -> READY constantly 1, read data on AD from edge e.

Source files
------------

// File: rtl/generic_bus_slave.sv
// Byte-wide memory or I/O slave on a multiplexed 8-bit address/data bus (ALE/RD_N/WR_N/READY).
// Wait-state generation (WAIT state, counter, READY) is built only when GBS_WAITSTATE_EN is defined.
module generic_bus_slave #(
  parameter int          IS_IO       = 0,
  parameter logic [19:0] BASE_ADDR   = 20'h1C000,
  parameter int          ADDR_BITS   = 9,
  parameter int          WAIT_STATES = 2
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        ALE,
  input  logic        IOM,
  input  logic        RD_N,
  input  logic        WR_N,
  input  logic [19:8] A,
  inout  wire  [7:0]  AD,
  output logic        READY,
  output logic        SEL
);

  localparam int          DEPTH    = 2 ** ADDR_BITS;
  localparam logic        IO_SLAVE = (IS_IO != 0);
  localparam logic [19:0] CMP_MASK = IO_SLAVE ? 20'h0FFFF : 20'hFFFFF;

`ifdef GBS_WAITSTATE_EN
  localparam logic [2:0] WS_CNT = 3'(WAIT_STATES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LATCHED = 3'd1,
    S_WAIT    = 3'd2,
    S_ACCESS  = 3'd3,
    S_DONE    = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LATCHED = 3'd1,
    S_ACCESS  = 3'd3,
    S_DONE    = 3'd4
  } state_e;
`endif

  // I/O slaves decode only the low 16 address bits; the window is aligned, so compare above the offset.
  function automatic logic hit_f(input logic [19:0] addr, input logic iom);
    logic [19:0] a_m;
    logic [19:0] b_m;
    a_m = (addr & CMP_MASK) >> ADDR_BITS;
    b_m = (BASE_ADDR & CMP_MASK) >> ADDR_BITS;
    return (iom == IO_SLAVE) && (a_m == b_m);
  endfunction

  state_e                 state_q, state_d;
  logic [19:0]            addr_q, addr_d;
  logic                   sel_q, sel_d;
  logic                   wr_q, wr_d;
  logic [7:0]             rdata_q, rdata_d;
  logic [7:0]             mem_q [DEPTH];
  logic [ADDR_BITS-1:0]   offset_s;
  logic                   one_strobe_s;
  logic                   mem_we_s;
  logic                   rd_load_s;
  logic                   ad_oe_s;
  logic                   unused_addr_s;
`ifdef GBS_WAITSTATE_EN
  logic [2:0]             cnt_q, cnt_d;
  logic                   ready_q, ready_d;
`else
  logic [2:0]             unused_ws_s;
`endif

  assign offset_s      = addr_q[ADDR_BITS-1:0];
  assign one_strobe_s  = RD_N ^ WR_N;
  assign unused_addr_s = ^addr_q[19:ADDR_BITS];

  // Address and hit are captured together on every ALE edge
  always_comb begin
    if (ALE) begin
      addr_d = {A, AD};
      sel_d  = hit_f({A, AD}, IOM);
    end else begin
      addr_d = addr_q;
      sel_d  = sel_q;
    end
  end

  // State register and all reset-cleared registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      addr_q  <= 20'h00000;
      sel_q   <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= 8'h00;
`ifdef GBS_WAITSTATE_EN
      cnt_q   <= 3'd0;
      ready_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
`ifdef GBS_WAITSTATE_EN
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
`endif
    end
  end

  // Next-state logic; ALE restarts the cycle from any state
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
`ifdef GBS_WAITSTATE_EN
    cnt_d   = cnt_q;
`endif
    if (ALE) begin
      state_d = S_LATCHED;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_LATCHED: begin
          if (!sel_q) begin
            state_d = S_IDLE;
          end else if (one_strobe_s) begin
            wr_d = !WR_N;
`ifdef GBS_WAITSTATE_EN
            if (WAIT_STATES == 0) begin
              state_d = S_ACCESS;
            end else begin
              state_d = S_WAIT;
              cnt_d   = WS_CNT;
            end
`else
            state_d = S_ACCESS;
`endif
          end else begin
            state_d = S_LATCHED;
          end
        end
`ifdef GBS_WAITSTATE_EN
        S_WAIT: begin
          if (cnt_q <= 3'd1) begin
            state_d = S_ACCESS;
            cnt_d   = 3'd0;
          end else begin
            state_d = S_WAIT;
            cnt_d   = cnt_q - 3'd1;
          end
        end
`endif
        S_ACCESS: begin
          state_d = S_DONE;
        end
        S_DONE: begin
          if (RD_N && WR_N) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Outputs: storage write / read capture on entry to ACCESS, bus drive, READY
  always_comb begin
    mem_we_s  = (state_d == S_ACCESS) && wr_d;
    rd_load_s = (state_d == S_ACCESS) && !wr_d;
    if (rd_load_s) begin
      rdata_d = mem_q[offset_s];
    end else begin
      rdata_d = rdata_q;
    end
    ad_oe_s = ((state_q == S_ACCESS) || (state_q == S_DONE)) && !wr_q && !RD_N && WR_N;
`ifdef GBS_WAITSTATE_EN
    ready_d = (state_d != S_WAIT);
`endif
  end

  // Storage is deliberately not reset
  always_ff @(posedge CLK) begin
    if (mem_we_s) begin
      mem_q[offset_s] <= AD;
    end
  end

  assign AD  = ad_oe_s ? rdata_q : 8'hzz;
  assign SEL = sel_q;

`ifdef GBS_WAITSTATE_EN
  assign READY = ready_q;
`else
  assign unused_ws_s = 3'(WAIT_STATES);
  assign READY       = 1'b1;
`endif

endmodule

// File: tb/tb_generic_bus_slave.sv
// Bench for generic_bus_slave: a memory slave and an I/O slave share one bus (AD pulled up, so Z reads FF).
// Table vectors, hand-written reset/illegal/restart sequences, then random cycles against a window model.
module tb_generic_bus_slave;

`ifdef GBS_WAITSTATE_EN
  localparam int WS_EFF = 2;
`else
  localparam int WS_EFF = 0;
`endif

  logic        CLK = 1'b0;
  logic        RESET_N, ALE, IOM, RD_N, WR_N;
  logic [19:8] A;
  wire  [7:0]  AD;
  logic [7:0]  m_dat;
  logic        m_oe;
  logic        READY_m, SEL_m, READY_io, SEL_io;

  int n_cmp = 0;
  int n_bad = 0;

  assign AD = m_oe ? m_dat : 8'hzz;

  for (genvar g = 0; g < 8; g++) begin : g_pull
    pullup pu (AD[g]);
  end

  always #5 CLK = ~CLK;

  generic_bus_slave u_mem (
    .CLK(CLK), .RESET_N(RESET_N), .ALE(ALE), .IOM(IOM), .RD_N(RD_N), .WR_N(WR_N),
    .A(A), .AD(AD), .READY(READY_m), .SEL(SEL_m)
  );

  generic_bus_slave #(.IS_IO(1), .BASE_ADDR(20'h0FF00), .ADDR_BITS(4), .WAIT_STATES(2)) u_io (
    .CLK(CLK), .RESET_N(RESET_N), .ALE(ALE), .IOM(IOM), .RD_N(RD_N), .WR_N(WR_N),
    .A(A), .AD(AD), .READY(READY_io), .SEL(SEL_io)
  );

  typedef struct {
    string       name;
    logic [19:0] addr;
    logic        iom;
    logic        wr;
    logic [7:0]  data;
    logic        sel_m;
    logic        sel_io;
    int          ws_m;
    int          ws_io;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t        vecs[$];
  logic [7:0]  mm [512];
  bit          vm [512];
  logic [7:0]  mio [16];
  bit          vio [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic addr_phase(input logic [19:0] addr, input logic iom);
    ALE = 1'b1; IOM = iom; A = addr[19:8]; m_dat = addr[7:0]; m_oe = 1'b1;
    tick();
    ALE = 1'b0; m_oe = 1'b0;
  endtask

  // Strobe phase: counts READY-low cycles per slave, checks read data in ACCESS and DONE
  task automatic data_phase(input string name, input logic wr, input logic [7:0] wdata,
                            input logic sel_m, input logic sel_io, input int ws_m, input int ws_io,
                            input logic [7:0] exp_rd, input logic rel);
    int lows_m, lows_io;
    check({name, "_sel_m"}, SEL_m, sel_m);
    check({name, "_sel_io"}, SEL_io, sel_io);
    if (wr) begin
      m_dat = wdata; m_oe = 1'b1; WR_N = 1'b0;
    end else begin
      RD_N = 1'b0;
    end
    lows_m = 0; lows_io = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (!READY_m)  lows_m++;
      if (!READY_io) lows_io++;
      if (READY_m && READY_io) break;
    end
    check({name, "_ws_m"}, lows_m, ws_m);
    check({name, "_ws_io"}, lows_io, ws_io);
    if (!wr) check({name, "_rd_access"}, AD, exp_rd);
    tick();
    if (!wr) check({name, "_rd_done"}, AD, exp_rd);
    if (rel) begin
      RD_N = 1'b1; WR_N = 1'b1; m_oe = 1'b0;
      tick();
      check({name, "_ad_released"}, AD, 8'hFF);
      check({name, "_ready_idle"}, {READY_m, READY_io}, 2'b11);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    RESET_N = 1'b0; ALE = 1'b0; IOM = 1'b0; RD_N = 1'b1; WR_N = 1'b1;
    A = 12'h000; m_dat = 8'h00; m_oe = 1'b0;
    @(negedge CLK);
    check("reset_ready", {READY_m, READY_io}, 2'b11);
    check("reset_sel", {SEL_m, SEL_io}, 2'b00);
    check("reset_ad_z", AD, 8'hFF);
    tick();
    RESET_N = 1'b1;
    tick();

    vecs.push_back('{"w_1C005",      20'h1C005, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, WS_EFF, 0, 8'hFF});
    vecs.push_back('{"r_1C005",      20'h1C005, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, WS_EFF, 0, 8'hA5});
    vecs.push_back('{"w_1C000",      20'h1C000, 1'b0, 1'b1, 8'h12, 1'b1, 1'b0, WS_EFF, 0, 8'hFF});
    vecs.push_back('{"w_1C200_miss", 20'h1C200, 1'b0, 1'b1, 8'h66, 1'b0, 1'b0, 0,      0, 8'hFF});
    vecs.push_back('{"r_1C200_miss", 20'h1C200, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0,      0, 8'hFF});
    vecs.push_back('{"r_1C000",      20'h1C000, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, WS_EFF, 0, 8'h12});
    vecs.push_back('{"w_1C1FF",      20'h1C1FF, 1'b0, 1'b1, 8'h0E, 1'b1, 1'b0, WS_EFF, 0, 8'hFF});
    vecs.push_back('{"r_1C1FF",      20'h1C1FF, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, WS_EFF, 0, 8'h0E});
    vecs.push_back('{"r_1BFFF_miss", 20'h1BFFF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0,      0, 8'hFF});
    vecs.push_back('{"io_w_iom0",    20'hFFF03, 1'b0, 1'b1, 8'h99, 1'b0, 1'b0, 0,      0, 8'hFF});
    vecs.push_back('{"io_w_FF03",    20'hFFF03, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, 0, WS_EFF, 8'hFF});
    vecs.push_back('{"io_r_FF03",    20'hFFF03, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 0, WS_EFF, 8'h3C});
    vecs.push_back('{"io_w_iom0_b",  20'hFFF03, 1'b0, 1'b1, 8'h99, 1'b0, 1'b0, 0,      0, 8'hFF});
    vecs.push_back('{"io_r_0FF03",   20'h0FF03, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 0, WS_EFF, 8'h3C});
    vecs.push_back('{"io_r_FF10",    20'hFFF10, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0,      0, 8'hFF});
    vecs.push_back('{"io_r_1C005",   20'h1C005, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0,      0, 8'hFF});
    vecs.push_back('{"r_1C005_b",    20'h1C005, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, WS_EFF, 0, 8'hA5});

    foreach (vecs[i]) begin
      addr_phase(vecs[i].addr, vecs[i].iom);
      data_phase(vecs[i].name, vecs[i].wr, vecs[i].data, vecs[i].sel_m, vecs[i].sel_io,
                 vecs[i].ws_m, vecs[i].ws_io, vecs[i].exp_rd, 1'b1);
    end

    // Reset in the middle of a write: no write may land
    addr_phase(20'h1C005, 1'b0);
    m_dat = 8'h5A; m_oe = 1'b1; WR_N = 1'b0;
`ifdef GBS_WAITSTATE_EN
    tick();
    check("rstw_in_wait_ready", READY_m, 1'b0);
`endif
    RESET_N = 1'b0;
    #1;
    check("rstw_ready_async", READY_m, 1'b1);
    check("rstw_sel_async", SEL_m, 1'b0);
    WR_N = 1'b1; m_oe = 1'b0;
    tick();
    RESET_N = 1'b1;
    tick();

    // Reset while driving read data: AD must float at once
    addr_phase(20'h1C005, 1'b0);
    RD_N = 1'b0;
    repeat (WS_EFF + 1) tick();
    check("rstr_drive", AD, 8'hA5);
    RESET_N = 1'b0;
    #1;
    check("rstr_ad_z_async", AD, 8'hFF);
    check("rstr_ready_async", READY_m, 1'b1);
    RD_N = 1'b1;
    tick();
    RESET_N = 1'b1;
    tick();
    addr_phase(20'h1C005, 1'b0);
    data_phase("rst_readback", 1'b0, 8'h00, 1'b1, 1'b0, WS_EFF, 0, 8'hA5, 1'b1);

    // Both strobes low: hold in LATCHED, then a plain read completes the same cycle
    addr_phase(20'h1C007, 1'b0);
    data_phase("w_1C007", 1'b1, 8'h11, 1'b1, 1'b0, WS_EFF, 0, 8'hFF, 1'b1);
    addr_phase(20'h1C007, 1'b0);
    RD_N = 1'b0; WR_N = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("ill_ready_%0d", i), READY_m, 1'b1);
      check($sformatf("ill_ad_z_%0d", i), AD, 8'hFF);
    end
    WR_N = 1'b1;
    data_phase("ill_then_rd", 1'b0, 8'h00, 1'b1, 1'b0, WS_EFF, 0, 8'h11, 1'b1);

    // ALE while DONE still has WR_N low restarts a new cycle
    addr_phase(20'h1C005, 1'b0);
    data_phase("w_keep", 1'b1, 8'h4B, 1'b1, 1'b0, WS_EFF, 0, 8'hFF, 1'b0);
    addr_phase(20'h1C00A, 1'b0);
    data_phase("w_restart", 1'b1, 8'hC3, 1'b1, 1'b0, WS_EFF, 0, 8'hFF, 1'b1);
    addr_phase(20'h1C00A, 1'b0);
    data_phase("r_restart", 1'b0, 8'h00, 1'b1, 1'b0, WS_EFF, 0, 8'hC3, 1'b1);
    addr_phase(20'h1C005, 1'b0);
    data_phase("r_keep", 1'b0, 8'h00, 1'b1, 1'b0, WS_EFF, 0, 8'h4B, 1'b1);

    // Random cycles against the window model
    for (int it = 0; it < 40; it++) begin
      int          kind, off, im, ii;
      logic [19:0] addr;
      logic        iom, wr, hm, hi;
      logic [7:0]  d, exp_rd;
      kind = $urandom_range(0, 4);
      off  = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) off = off + 496;
      case (kind)
        0, 1: begin addr = 20'h1C000 + 20'(off); iom = 1'b0; end
        2:    begin addr = {4'($urandom_range(0, 15)), 16'hFF00 + 16'($urandom_range(0, 15))}; iom = 1'b1; end
        3:    begin addr = 20'h1C200 + 20'(off); iom = 1'($urandom_range(0, 1)); end
        default: begin addr = 20'($urandom()); iom = 1'($urandom_range(0, 1)); end
      endcase
      hm = !iom && (addr >= 20'h1C000) && (addr <= 20'h1C1FF);
      hi = iom && (addr[15:0] >= 16'hFF00) && (addr[15:0] <= 16'hFF0F);
      im = int'(addr) - 'h1C000;
      ii = int'(addr[15:0]) - 'hFF00;
      wr = 1'($urandom_range(0, 1));
      d  = 8'($urandom_range(0, 254));
      if (hm && !vm[im]) wr = 1'b1;
      if (hi && !vio[ii]) wr = 1'b1;
      exp_rd = hm ? mm[im] : (hi ? mio[ii] : 8'hFF);
      addr_phase(addr, iom);
      data_phase($sformatf("rnd%0d_%05h", it, addr), wr, d, hm, hi,
                 hm ? WS_EFF : 0, hi ? WS_EFF : 0, exp_rd, 1'b1);
      if (wr && hm) begin mm[im] = d; vm[im] = 1'b1; end
      if (wr && hi) begin mio[ii] = d; vio[ii] = 1'b1; end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
